dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port; the core's memory stage is the initiator.
- Accepts one word load/store request at a time over a valid/ready handshake.
- Models a configurable access latency and returns read data and an alignment error flag over a valid/ready response channel.
- Replaces the zero-latency combinational data memory, so the pipeline can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_byte_array.sv | 41 ++++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int         BYTE_W          = 8;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_byte_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_array
// Description : Byte-addressed storage with a little-endian word write/read port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int ADDRESS_REAL_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          i_wrEn,
    input  logic [ADDRESS_REAL_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]              i_wrData,
    output logic [WIDTH-1:0]              o_rdData
);

    localparam int c_LANES = WIDTH / BYTE_W;

    logic [BYTE_W-1:0] r_mem [2**ADDRESS_REAL_WIDTH];

    // Lane addresses wrap inside the array, matching the aliasing of the port address.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            for (int i = 0; i < c_LANES; i++) begin
                r_mem[i_addr + ADDRESS_REAL_WIDTH'(i)] <= i_wrData[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        o_rdData = '0;
        for (int i = 0; i < c_LANES; i++) begin
            o_rdData[i*BYTE_W +: BYTE_W] = r_mem[i_addr + ADDRESS_REAL_WIDTH'(i)];
        end
    end

endmodule : dmem_byte_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Latency-modelling data-memory responder with valid/ready channels.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int ADDRESS_REAL_WIDTH = 12,
    parameter int LATENCY            = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             busy
);

    localparam logic [3:0] c_LAT_LOAD = 4'(LATENCY - 1);

    dmem_state_t                   r_state;
    logic [3:0]                    r_count;
    logic                          r_we;
    logic [ADDRESS_REAL_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]              r_wdata;
    logic                          r_err;
    logic                          r_respValid;
    logic [WIDTH-1:0]              r_respRdata;
    logic                          r_respErr;
    logic                          r_busy;

    logic                          w_fromReq;
    logic                          w_reqErr;
    logic                          w_enterResp;
    logic                          w_accWe;
    logic [ADDRESS_REAL_WIDTH-1:0] w_accAddr;
    logic [WIDTH-1:0]              w_accWdata;
    logic                          w_accErr;
    logic                          w_memWrEn;
    logic [WIDTH-1:0]              w_rdData;
    logic                          w_unusedAddrBits;

    assign w_unusedAddrBits = ^req_addr[WIDTH-1:ADDRESS_REAL_WIDTH];

    assign w_fromReq = (r_state == IDLE);
    assign w_reqErr  = (req_addr[1:0] & WORD_ALIGN_MASK) != 2'b00;

    // With single-cycle latency the access happens on the acceptance edge, so the
    // live request feeds the array instead of the captured copy.
    assign w_enterResp = (w_fromReq && req_valid && (LATENCY == 1)) ||
                         ((r_state == WAIT) && (r_count == 4'd1));
    assign w_accWe     = w_fromReq ? req_we    : r_we;
    assign w_accAddr   = w_fromReq ? req_addr[ADDRESS_REAL_WIDTH-1:0] : r_addr;
    assign w_accWdata  = w_fromReq ? req_wdata : r_wdata;
    assign w_accErr    = w_fromReq ? w_reqErr  : r_err;
    assign w_memWrEn   = w_enterResp && w_accWe && !w_accErr && !rst;

    dmem_byte_array #(
        .WIDTH              (WIDTH),
        .ADDRESS_REAL_WIDTH (ADDRESS_REAL_WIDTH)
    ) u_byteArray (
        .clk      (clk),
        .i_wrEn   (w_memWrEn),
        .i_addr   (w_accAddr),
        .i_wrData (w_accWdata),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_respValid <= 1'b0;
            r_respRdata <= '0;
            r_respErr   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr[ADDRESS_REAL_WIDTH-1:0];
                        r_wdata <= req_wdata;
                        r_err   <= w_reqErr;
                        r_count <= c_LAT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state     <= IDLE;
                        r_respValid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_enterResp) begin
                r_respValid <= 1'b1;
                r_respErr   <= w_accErr;
                r_respRdata <= (w_accErr || w_accWe) ? '0 : w_rdData;
            end
        end
    end

    // Ready only from IDLE, so nothing is accepted on the handshake cycle.
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_respValid;
    assign resp_rdata = r_respRdata;
    assign resp_err   = r_respErr;
    assign busy       = r_busy;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Randomized scoreboard bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int WIDTH = 32;
    localparam int ARW   = 12;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [WIDTH-1:0] req_addr = '0, req_wdata = '0;
    logic             req_ready, resp_valid, resp_err, busy;
    logic [WIDTH-1:0] resp_rdata;

    logic             reqValid1 = 1'b0, reqWe1 = 1'b0, respReady1 = 1'b1;
    logic [WIDTH-1:0] reqAddr1 = '0, reqWdata1 = '0;
    logic             reqReady1, respValid1, respErr1, busy1;
    logic [WIDTH-1:0] respRdata1;

    always #5 clk = ~clk;

    dmem_responder #(.WIDTH(WIDTH), .ADDRESS_REAL_WIDTH(ARW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    dmem_responder #(.WIDTH(WIDTH), .ADDRESS_REAL_WIDTH(ARW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(reqValid1), .req_ready(reqReady1),
        .req_we(reqWe1), .req_addr(reqAddr1), .req_wdata(reqWdata1),
        .resp_valid(respValid1), .resp_ready(respReady1), .resp_rdata(respRdata1),
        .resp_err(respErr1), .busy(busy1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    logic [7:0]  model [4096];
    int          nChecks = 0;
    int          nFail   = 0;
    int          cyc = 0, acceptCyc = 0;
    bit          outstanding = 0;
    bit          prevValid = 0;
    int          readyMode = 1;
    bit          undoValid = 0;
    int          undoAddr = 0;
    logic [7:0]  undoBytes [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tracks the transaction window from the bench's side of the handshakes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (req_valid && req_ready) begin
                outstanding = 1;
                acceptCyc   = cyc;
            end
            if (resp_valid && resp_ready) outstanding = 0;
            cyc++;
        end
    end

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       resp_ready = 1'b0;
            1:       resp_ready = 1'b1;
            default: resp_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 0;
        end else begin
            chk("busy", {31'd0, busy}, {31'd0, outstanding});
            chk("req_ready", {31'd0, req_ready}, {31'd0, !outstanding});
            if (resp_valid) begin
                if (expQ.size() == 0) begin
                    chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
                end else begin
                    if (!prevValid) chk("latency", cyc - acceptCyc, LAT);
                    chk("resp_rdata", resp_rdata, expQ[0].rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, expQ[0].err});
                    if (resp_ready) void'(expQ.pop_front());
                end
            end
            prevValid = resp_valid;
        end
    end

    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   a;
        int   n = 0;
        @(posedge clk); #1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        a       = int'(addr[ARW-1:0]);
        e.err   = (addr[1:0] != 2'b00);
        e.rdata = '0;
        undoValid = 0;
        if (!e.err) begin
            if (we) begin
                undoValid = 1;
                undoAddr  = a;
                for (int i = 0; i < 4; i++) begin
                    undoBytes[i] = model[a+i];
                    model[a+i]   = wdata[i*8 +: 8];
                end
            end else begin
                e.rdata = {model[a+3], model[a+2], model[a+1], model[a]};
            end
        end
        expQ.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic waitDone();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!outstanding && expQ.size() == 0) return;
        end
        chk("done_timeout", {31'd0, outstanding}, 32'd0);
        expQ.delete();
    endtask

    task automatic l1Txn(input string name, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] expData, input bit expErr);
        @(posedge clk); #1;
        reqWe1 = we; reqAddr1 = addr; reqWdata1 = wdata; reqValid1 = 1'b1;
        @(negedge clk);
        chk({name, "_ready"}, {31'd0, reqReady1}, 32'd1);
        @(posedge clk); #1;
        reqValid1 = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, respValid1}, 32'd1);
        chk({name, "_rdata"}, respRdata1, expData);
        chk({name, "_err"}, {31'd0, respErr1}, {31'd0, expErr});
        @(negedge clk);
        chk({name, "_idle"}, {30'd0, respValid1, busy1}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bytesExp;
        for (int i = 0; i < 4096; i++) model[i] = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_l1_valid", {31'd0, respValid1}, 32'd0);
        rst = 1'b0;

        issue(1, 32'h10, 32'hDEADBEEF); waitDone();
        issue(0, 32'h10, 32'h0);        waitDone();

        issue(1, 32'h20, 32'h11223344); waitDone();
        bytesExp = 32'h11223344;
        for (int i = 0; i < 4; i++)
            chk("byte_order", {24'd0, dut.u_byteArray.r_mem[32+i]}, {24'd0, bytesExp[i*8 +: 8]});
        issue(0, 32'h20, 32'h0);        waitDone();

        issue(0, 32'h22, 32'h0);        waitDone();
        issue(1, 32'h21, 32'hFFFFFFFF); waitDone();
        issue(0, 32'h20, 32'h0);        waitDone();

        readyMode = 0;
        issue(0, 32'h20, 32'h0);
        for (int n = 0; n < 50 && !resp_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_rdata", resp_rdata, 32'h11223344);
        end
        readyMode = 1;
        waitDone();
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

        issue(1, 32'h1004, 32'hCAFEF00D); waitDone();
        issue(0, 32'h0004, 32'h0);        waitDone();

        // Reset lands while the store is still counting down.
        issue(1, 32'h30, 32'h0);        waitDone();
        issue(1, 32'h30, 32'h12345678);
        #2 rst = 1'b1;
        expQ.delete();
        if (undoValid)
            for (int i = 0; i < 4; i++) model[undoAddr+i] = undoBytes[i];
        @(negedge clk);
        chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        issue(0, 32'h30, 32'h0);        waitDone();

        l1Txn("l1_store", 1, 32'h8, 32'hA5A55A5A, 32'h0, 0);
        l1Txn("l1_load", 0, 32'h8, 32'h0, 32'hA5A55A5A, 0);
        l1Txn("l1_misal", 0, 32'h9, 32'h0, 32'h0, 1);

        for (int w = 0; w < 32; w++) begin
            issue(1, 32'(w * 4), 32'h0);
            waitDone();
        end

        readyMode = 2;
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) * 4);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            issue(1'($urandom), a, $urandom);
            if ($urandom_range(0, 4) == 0) waitDone();
        end
        readyMode = 1;
        waitDone();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
